// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC predictor: BTB entry layout,
// 2-bit counter encodings and default reset/trap vectors.
package npc_pkg;

    localparam int unsigned NPC_XLEN = 32;

    localparam logic [NPC_XLEN-1:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [NPC_XLEN-1:0] DEF_TRAP_VEC  = 32'h0000_0100;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Tag holds the PC shifted right by IDX+2, zero-extended to full width.
    typedef struct packed {
        logic                valid;
        logic [NPC_XLEN-1:0] tag;
        logic [NPC_XLEN-1:0] target;
        logic [1:0]          ctr;
        logic                jump;
    } btb_entry_t;

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup port and an
// edge-registered update port with saturating 2-bit counters.
module npc_btb
    import npc_pkg::*;
#(
    parameter int unsigned XLEN        = NPC_XLEN,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            lk_taken_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            up_en_i,
    input  logic [XLEN-1:0] up_pc_i,
    input  logic            up_taken_i,
    input  logic            up_jump_i,
    input  logic [XLEN-1:0] up_target_i
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);

    function automatic logic [NPC_XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
        return NPC_XLEN'(pc >> (IDX + 2));
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'b01;
    endfunction

    btb_entry_t     mem_q [BTB_ENTRIES];
    btb_entry_t     lk_entry_s;
    btb_entry_t     up_entry_s;
    btb_entry_t     entry_d;
    logic [IDX-1:0] lk_idx_s;
    logic [IDX-1:0] up_idx_s;
    logic           lk_hit_s;
    logic           up_hit_s;
    logic           wr_s;

    assign lk_idx_s   = lk_pc_i[IDX+1:2];
    assign up_idx_s   = up_pc_i[IDX+1:2];
    assign lk_entry_s = mem_q[lk_idx_s];
    assign up_entry_s = mem_q[up_idx_s];
    assign lk_hit_s   = lk_entry_s.valid && (lk_entry_s.tag == tag_of(lk_pc_i));
    assign up_hit_s   = up_entry_s.valid && (up_entry_s.tag == tag_of(up_pc_i));

    // Lookup reads pre-update contents, so a same-cycle write is not forwarded.
    always_comb begin
        if (lk_hit_s) begin
            lk_taken_o  = lk_entry_s.jump | lk_entry_s.ctr[1];
            lk_target_o = XLEN'(lk_entry_s.target);
        end else begin
            lk_taken_o  = 1'b0;
            lk_target_o = '0;
        end
    end

    // Next contents of the indexed entry: train on hit, allocate on taken miss.
    always_comb begin
        entry_d = up_entry_s;
        wr_s    = 1'b0;
        if (up_en_i && up_hit_s) begin
            wr_s = 1'b1;
            if (up_taken_i) begin
                entry_d.ctr    = ctr_inc(up_entry_s.ctr);
                entry_d.target = NPC_XLEN'(up_target_i);
                entry_d.jump   = up_jump_i;
            end else begin
                entry_d.ctr    = ctr_dec(up_entry_s.ctr);
            end
        end else if (up_en_i && up_taken_i) begin
            wr_s           = 1'b1;
            entry_d.valid  = 1'b1;
            entry_d.tag    = tag_of(up_pc_i);
            entry_d.target = NPC_XLEN'(up_target_i);
            entry_d.ctr    = up_jump_i ? ST : WT;
            entry_d.jump   = up_jump_i;
        end else begin
            wr_s = 1'b0;
        end
    end

    // Entry storage; reset invalidates every entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_s) begin
            mem_q[up_idx_s] <= entry_d;
        end
    end

endmodule

// File: rtl/npc_predict.sv
// Next-PC generator: owns the fetch PC, issues fetch requests, follows BTB
// predictions and applies execute-stage corrections and misaligned-target traps.
module npc_predict
    import npc_pkg::*;
#(
    parameter int unsigned     XLEN        = NPC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
    parameter int unsigned     BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    output logic            f_valid,
    input  logic            f_ready,
    output logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(32'd4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            started_q;
    logic [XLEN-1:0] act_next_s;
    logic [XLEN-1:0] pred_next_s;
    logic            misalign_s;
    logic            redirect_s;
    logic            btb_up_s;

    assign f_valid  = started_q & ~stall;
    assign f_pc     = pc_q;
    assign btb_up_s = ex_valid & (ex_is_branch | ex_is_jump) & ~misalign_s;

    npc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rstn        (rstn),
        .lk_pc_i     (pc_q),
        .lk_taken_o  (f_pred_taken),
        .lk_target_o (f_pred_target),
        .up_en_i     (btb_up_s),
        .up_pc_i     (ex_pc),
        .up_taken_i  (ex_taken),
        .up_jump_i   (ex_is_jump),
        .up_target_i (ex_target)
    );

    // Resolution check: compare actual vs predicted successor of the resolved PC.
    always_comb begin
        act_next_s    = ex_taken ? ex_target : ex_pc + PC_INC;
        pred_next_s   = ex_pred_taken ? ex_pred_target : ex_pc + PC_INC;
        misalign_s    = ex_valid & ex_taken & (ex_target[1:0] != 2'b00);
        redirect_s    = ex_valid & ((act_next_s != pred_next_s) | misalign_s);
        misalign_exc  = misalign_s;
        misalign_addr = misalign_s ? ex_target : '0;
        redirect      = redirect_s;
    end

    // PC priority: trap, redirect, hold (not started / stall / waiting), predict, sequential.
    always_comb begin
        if (misalign_s) begin
            pc_d = TRAP_VEC;
        end else if (redirect_s) begin
            pc_d = act_next_s;
        end else if (!started_q || stall || (f_valid && !f_ready)) begin
            pc_d = pc_q;
        end else if (f_pred_taken) begin
            pc_d = f_pred_target;
        end else begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC and fetch-start registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= RESET_VEC;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            started_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_npc_predict.sv
// Self-checking bench for npc_predict: directed scenarios followed by random
// traffic compared against a behavioural next-PC/BTB model.
module tb_npc_predict;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk, rstn, stall, f_valid, f_ready, f_pred_taken;
    logic [31:0] f_pc, f_pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect, misalign_exc;
    logic [31:0] misalign_addr;

    int checks   = 0;
    int failures = 0;

    npc_predict #(.XLEN(32), .RESET_VEC(RV), .TRAP_VEC(TV), .BTB_ENTRIES(8)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .f_valid(f_valid), .f_ready(f_ready),
        .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_target(f_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: PC, started flag, and an 8-slot table indexed by (pc/4)%8.
    logic [31:0] m_pc;
    bit          m_started;
    bit          b_v   [8];
    logic [31:0] b_tag [8];
    logic [31:0] b_tgt [8];
    int          b_ctr [8];
    bit          b_j   [8];

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd8);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return b_v[slot(pc)] && (b_tag[slot(pc)] == pc / 32'd32);
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (b_j[slot(pc)] || b_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_hit(pc) ? b_tgt[slot(pc)] : 32'h0;
    endfunction

    function automatic bit m_mis();
        return ex_valid && ex_taken && (ex_target % 32'd4 != 32'd0);
    endfunction

    function automatic logic [31:0] m_act();
        return ex_taken ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic bit m_red();
        logic [31:0] prd;
        prd = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
        return ex_valid && ((m_act() != prd) || m_mis());
    endfunction

    task automatic model_reset();
        m_pc = RV;
        m_started = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_v[i] = 1'b0; b_ctr[i] = 0; b_j[i] = 1'b0; b_tag[i] = 32'h0; b_tgt[i] = 32'h0;
        end
    endtask

    task automatic model_tick();
        logic [31:0] nxt;
        int s;
        if (m_mis()) nxt = TV;
        else if (m_red()) nxt = m_act();
        else if (!m_started || stall || !f_ready) nxt = m_pc;
        else if (m_ptaken(m_pc)) nxt = m_ptarget(m_pc);
        else nxt = m_pc + 32'd4;
        if (ex_valid && (ex_is_branch || ex_is_jump) && !m_mis()) begin
            s = slot(ex_pc);
            if (m_hit(ex_pc)) begin
                if (ex_taken) begin
                    b_ctr[s] = (b_ctr[s] < 3) ? b_ctr[s] + 1 : 3;
                    b_tgt[s] = ex_target;
                    b_j[s]   = ex_is_jump;
                end else begin
                    b_ctr[s] = (b_ctr[s] > 0) ? b_ctr[s] - 1 : 0;
                end
            end else if (ex_taken) begin
                b_v[s] = 1'b1; b_tag[s] = ex_pc / 32'd32; b_tgt[s] = ex_target;
                b_ctr[s] = ex_is_jump ? 3 : 2; b_j[s] = ex_is_jump;
            end
        end
        m_pc = nxt;
        m_started = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit br, input bit jp, input bit tk,
                           input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_pc = pc; ex_is_branch = br; ex_is_jump = jp; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    // Non-branch redirect used to steer fetch to an address without training the BTB.
    task automatic go_to(input logic [31:0] addr);
        resolve(32'h0000_0FF0, 1'b0, 1'b0, 1'b1, addr, 1'b0, 32'h0);
        tick();
        clear_ex();
    endtask

    task automatic test_reset();
        clear_ex(); stall = 1'b0; f_ready = 1'b1; rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL rst_fvalid got=%b exp=0", f_valid); end
        checks++; if (f_pc !== RV) begin failures++; $display("FAIL rst_fpc got=%h exp=%h", f_pc, RV); end
        checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_ptaken got=%b exp=0", f_pred_taken); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b exp=0", redirect); end
        resolve(32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL rst_redirect_comb got=%b exp=1", redirect); end
        clear_ex();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL pre_start_fvalid got=%b exp=0", f_valid); end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (f_pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc got=%h exp=%h", f_pc, 32'(4 * i)); end
            checks++; if (f_valid !== 1'b1 || f_pred_taken !== 1'b0) begin
                failures++; $display("FAIL seq_valid_pred got=%b/%b exp=1/0", f_valid, f_pred_taken); end
            tick();
        end
    endtask

    task automatic test_handshake();
        f_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (f_pc !== 32'h10 || f_valid !== 1'b1) begin
                failures++; $display("FAIL hs_hold pc=%h valid=%b exp=00000010/1", f_pc, f_valid); end
            tick();
        end
        f_ready = 1'b1;
        @(negedge clk);
        checks++; if (f_pc !== 32'h10) begin failures++; $display("FAIL hs_accept got=%h exp=00000010", f_pc); end
        tick();
        @(negedge clk);
        checks++; if (f_pc !== 32'h14) begin failures++; $display("FAIL hs_next got=%h exp=00000014", f_pc); end
    endtask

    task automatic test_branch_learn();
        resolve(32'h20, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL bl_redirect got=%b exp=1", redirect); end
        tick(); clear_ex();
        @(negedge clk);
        checks++; if (f_pc !== 32'h80) begin failures++; $display("FAIL bl_target got=%h exp=00000080", f_pc); end
        go_to(32'h20);
        @(negedge clk);
        checks++; if (f_pc !== 32'h20 || f_pred_taken !== 1'b1 || f_pred_target !== 32'h80) begin
            failures++; $display("FAIL bl_predict pc=%h pt=%b ptgt=%h exp=00000020/1/00000080", f_pc, f_pred_taken, f_pred_target); end
        tick();
        @(negedge clk);
        checks++; if (f_pc !== 32'h80) begin failures++; $display("FAIL bl_follow got=%h exp=00000080", f_pc); end
    endtask

    task automatic test_branch_decay();
        resolve(32'h20, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        @(negedge clk);
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL bd_redirect got=%b exp=1", redirect); end
        tick(); clear_ex();
        @(negedge clk);
        checks++; if (f_pc !== 32'h24) begin failures++; $display("FAIL bd_fallthru got=%h exp=00000024", f_pc); end
        resolve(32'h20, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL bd_noredirect got=%b exp=0", redirect); end
        tick(); clear_ex();
        go_to(32'h20);
        @(negedge clk);
        checks++; if (f_pc !== 32'h20 || f_pred_taken !== 1'b0) begin
            failures++; $display("FAIL bd_weak pc=%h pt=%b exp=00000020/0", f_pc, f_pred_taken); end
    endtask

    task automatic test_misalign();
        resolve(32'h30, 1'b1, 1'b0, 1'b1, 32'h102, 1'b1, 32'h102);
        @(negedge clk);
        checks++; if (misalign_exc !== 1'b1 || misalign_addr !== 32'h102 || redirect !== 1'b1) begin
            failures++; $display("FAIL ma_flags exc=%b addr=%h red=%b exp=1/00000102/1", misalign_exc, misalign_addr, redirect); end
        tick(); clear_ex();
        @(negedge clk);
        checks++; if (f_pc !== TV || misalign_addr !== 32'h0) begin
            failures++; $display("FAIL ma_trap pc=%h addr=%h exp=%h/00000000", f_pc, misalign_addr, TV); end
        go_to(32'h30);
        @(negedge clk);
        checks++; if (f_pred_taken !== 1'b0) begin failures++; $display("FAIL ma_noalloc got=%b exp=0", f_pred_taken); end
        stall = 1'b1;
        resolve(32'h30, 1'b0, 1'b1, 1'b1, 32'h206, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (f_valid !== 1'b0 || misalign_exc !== 1'b1) begin
            failures++; $display("FAIL ma_stall valid=%b exc=%b exp=0/1", f_valid, misalign_exc); end
        tick(); clear_ex(); stall = 1'b0;
        @(negedge clk);
        checks++; if (f_pc !== TV) begin failures++; $display("FAIL ma_stall_trap got=%h exp=%h", f_pc, TV); end
    endtask

    task automatic test_replace_wrap();
        resolve(32'h40, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        resolve(32'h60, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        tick(); clear_ex();
        go_to(32'h60);
        @(negedge clk);
        checks++; if (f_pred_taken !== 1'b1 || f_pred_target !== 32'h300) begin
            failures++; $display("FAIL rp_new pt=%b ptgt=%h exp=1/00000300", f_pred_taken, f_pred_target); end
        go_to(32'h40);
        @(negedge clk);
        checks++; if (f_pc !== 32'h40 || f_pred_taken !== 1'b0) begin
            failures++; $display("FAIL rp_evicted pc=%h pt=%b exp=00000040/0", f_pc, f_pred_taken); end
        go_to(32'hFFFF_FFFC);
        @(negedge clk);
        checks++; if (f_pc !== 32'hFFFF_FFFC || f_pred_taken !== 1'b0) begin
            failures++; $display("FAIL wr_top pc=%h pt=%b exp=fffffffc/0", f_pc, f_pred_taken); end
        tick();
        @(negedge clk);
        checks++; if (f_pc !== 32'h0) begin failures++; $display("FAIL wr_wrap got=%h exp=00000000", f_pc); end
    endtask

    task automatic test_midreset();
        @(posedge clk);
        #2 rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (f_valid !== 1'b0 || f_pc !== RV || f_pred_taken !== 1'b0) begin
            failures++; $display("FAIL mr_clear valid=%b pc=%h pt=%b exp=0/%h/0", f_valid, f_pc, f_pred_taken, RV); end
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] e_tgt;
        int kind;
        for (int n = 0; n < 800; n++) begin
            kind = int'($urandom_range(0, 2));
            stall   = ($urandom_range(0, 7) == 0);
            f_ready = ($urandom_range(0, 3) != 0);
            e_tgt   = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 9) == 0) e_tgt = e_tgt | 32'($urandom_range(1, 3));
            resolve(32'($urandom_range(0, 63)) << 2, kind == 1, kind == 2,
                    (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1)), e_tgt,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? e_tgt : 32'($urandom_range(0, 63)) << 2);
            ex_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (f_pc !== m_pc || f_valid !== (m_started && !stall)) begin
                failures++; $display("FAIL rnd_fetch n=%0d pc=%h valid=%b exp=%h/%b", n, f_pc, f_valid, m_pc, m_started && !stall); end
            checks++; if (f_pred_taken !== m_ptaken(m_pc) || f_pred_target !== m_ptarget(m_pc)) begin
                failures++; $display("FAIL rnd_pred n=%0d pt=%b ptgt=%h exp=%b/%h", n, f_pred_taken, f_pred_target, m_ptaken(m_pc), m_ptarget(m_pc)); end
            checks++; if (redirect !== m_red() || misalign_exc !== m_mis() || misalign_addr !== (m_mis() ? ex_target : 32'h0)) begin
                failures++; $display("FAIL rnd_resolve n=%0d red=%b exc=%b addr=%h exp=%b/%b", n, redirect, misalign_exc, misalign_addr, m_red(), m_mis()); end
            tick();
        end
        clear_ex(); stall = 1'b0; f_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_handshake();
        test_branch_learn();
        test_branch_decay();
        test_misalign();
        test_replace_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
